// File: rtl/i3c_pkg.sv
// Shared types and default thresholds for the I3C bus monitor.
// Bus state encoding plus reset-time tuning defaults.
package i3c_pkg;

    typedef enum logic [1:0] {
        FREE_WAIT,
        FREE,
        IDLE,
        BUSY
    } bus_state_e;

    localparam int DEF_FILT_W     = 4;
    localparam int DEF_CNT_W      = 20;
    localparam int DEF_T_FILT     = 3;
    localparam int DEF_T_BUS_FREE = 10;
    localparam int DEF_T_BUS_IDLE = 50;

endpackage

// File: rtl/i3c_line_filter.sv
// Glitch filter for one bus line: output follows raw only after
// raw has differed from it for threshold+1 consecutive cycles.
module i3c_line_filter #(
    parameter int FILT_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              raw,
    input  logic [FILT_W-1:0] threshold,
    output logic              filtered
);

    logic [FILT_W-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filtered <= 1'b1;
            cnt      <= '0;
        end else if (raw == filtered) begin
            cnt <= '0;
        end else if (cnt == threshold) begin
            filtered <= raw;
            cnt      <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + FILT_W'(1);
        end
    end

endmodule

// File: rtl/i3c_bus_monitor.sv
// I3C bus-condition monitor: filtered lines, SCL edges,
// START/repeated-START/STOP pulses and busy/free/idle tracking.
module i3c_bus_monitor
    import i3c_pkg::*;
#(
    parameter int FILT_W = DEF_FILT_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic              scl_i,
    input  logic              sda_i,
    input  logic [FILT_W-1:0] t_filt_i,
    input  logic [CNT_W-1:0]  t_bus_free_i,
    input  logic [CNT_W-1:0]  t_bus_idle_i,
    output logic              scl_o,
    output logic              sda_o,
    output logic              scl_posedge_o,
    output logic              scl_negedge_o,
    output logic              start_det_o,
    output logic              rstart_det_o,
    output logic              stop_det_o,
    output logic              bus_busy_o,
    output logic              bus_free_o,
    output logic              bus_idle_o
);

    logic scl_f, sda_f;
    logic scl_q, sda_q;
    bus_state_e state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
    logic pos_d, neg_d, start_d, rstart_d, stop_d;
    logic scl_rise, scl_fall, scl_hi, both_hi;
    logic start_c, stop_c;

    i3c_line_filter #(.FILT_W(FILT_W)) u_scl_filt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .raw       (scl_i),
        .threshold (t_filt_i),
        .filtered  (scl_f)
    );

    i3c_line_filter #(.FILT_W(FILT_W)) u_sda_filt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .raw       (sda_i),
        .threshold (t_filt_i),
        .filtered  (sda_f)
    );

    // SDA conditions only count while SCL is stably high across both samples
    assign scl_rise  = ~scl_q & scl_f;
    assign scl_fall  = scl_q & ~scl_f;
    assign scl_hi    = scl_q & scl_f;
    assign both_hi   = scl_f & sda_f;
    assign start_c   = scl_hi & sda_q & ~sda_f;
    assign stop_c    = scl_hi & ~sda_q & sda_f;
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        pos_d    = 1'b0;
        neg_d    = 1'b0;
        start_d  = 1'b0;
        rstart_d = 1'b0;
        stop_d   = 1'b0;
        if (!enable_i) begin
            state_d = FREE_WAIT;
            timer_d = '0;
        end else begin
            pos_d = scl_rise;
            neg_d = scl_fall;
            if (start_c) begin
                rstart_d = (state_q == BUSY);
                start_d  = (state_q != BUSY);
                state_d  = BUSY;
                timer_d  = '0;
            end else if (stop_c) begin
                stop_d  = 1'b1;
                state_d = FREE_WAIT;
                timer_d = '0;
            end else begin
                unique case (state_q)
                    FREE_WAIT: begin
                        timer_d = both_hi ? timer_inc : '0;
                        if (both_hi && timer_q >= t_bus_free_i)
                            state_d = FREE;
                    end
                    FREE, IDLE: begin
                        if (scl_fall) begin
                            state_d = FREE_WAIT;
                            timer_d = '0;
                        end else begin
                            if (both_hi)
                                timer_d = timer_inc;
                            if (state_q == FREE && timer_q >= t_bus_idle_i)
                                state_d = IDLE;
                        end
                    end
                    BUSY: timer_d = '0;
                    default: state_d = FREE_WAIT;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= FREE_WAIT;
            timer_q       <= '0;
            scl_q         <= 1'b1;
            sda_q         <= 1'b1;
            scl_posedge_o <= 1'b0;
            scl_negedge_o <= 1'b0;
            start_det_o   <= 1'b0;
            rstart_det_o  <= 1'b0;
            stop_det_o    <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            scl_q         <= scl_f;
            sda_q         <= sda_f;
            scl_posedge_o <= pos_d;
            scl_negedge_o <= neg_d;
            start_det_o   <= start_d;
            rstart_det_o  <= rstart_d;
            stop_det_o    <= stop_d;
        end
    end

    assign scl_o      = scl_f;
    assign sda_o      = sda_f;
    assign bus_busy_o = (state_q == BUSY);
    assign bus_free_o = (state_q == FREE) || (state_q == IDLE);
    assign bus_idle_o = (state_q == IDLE);

endmodule

// File: tb/tb_i3c_bus_monitor.sv
// Directed bench for i3c_bus_monitor: vector table plus
// hand-written multi-cycle sequences.
module tb_i3c_bus_monitor;
    import i3c_pkg::*;

    localparam int FW = 4;
    localparam int CW = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en, scl, sda;
    logic [FW-1:0] t_filt;
    logic [CW-1:0] t_free, t_idle;
    logic scl_o, sda_o, scl_pos, scl_neg;
    logic start_det, rstart_det, stop_det;
    logic busy, free, idle;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       scl;
        logic       sda;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[19];

    i3c_bus_monitor #(.FILT_W(FW), .CNT_W(CW)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .enable_i      (en),
        .scl_i         (scl),
        .sda_i         (sda),
        .t_filt_i      (t_filt),
        .t_bus_free_i  (t_free),
        .t_bus_idle_i  (t_idle),
        .scl_o         (scl_o),
        .sda_o         (sda_o),
        .scl_posedge_o (scl_pos),
        .scl_negedge_o (scl_neg),
        .start_det_o   (start_det),
        .rstart_det_o  (rstart_det),
        .stop_det_o    (stop_det),
        .bus_busy_o    (busy),
        .bus_free_o    (free),
        .bus_idle_o    (idle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [9:0] outs();
        return {scl_o, sda_o, scl_pos, scl_neg, start_det,
                rstart_det, stop_det, busy, free, idle};
    endfunction

    initial begin
        logic bad;

        // {scl_o,sda_o,pos,neg,start,rstart,stop,busy,free,idle}
        tbl[0]  = '{1'b1, 1'b1, 10'b1100000000};
        tbl[1]  = '{1'b1, 1'b1, 10'b1100000000};
        tbl[2]  = '{1'b1, 1'b1, 10'b1100000010};
        tbl[3]  = '{1'b1, 1'b1, 10'b1100000010};
        tbl[4]  = '{1'b1, 1'b0, 10'b1000000011};
        tbl[5]  = '{1'b1, 1'b0, 10'b1000100100};
        tbl[6]  = '{1'b0, 1'b0, 10'b0000000100};
        tbl[7]  = '{1'b0, 1'b1, 10'b0101000100};
        tbl[8]  = '{1'b1, 1'b1, 10'b1100000100};
        tbl[9]  = '{1'b1, 1'b0, 10'b1010000100};
        tbl[10] = '{1'b1, 1'b0, 10'b1000010100};
        tbl[11] = '{1'b1, 1'b1, 10'b1100000100};
        tbl[12] = '{1'b1, 1'b1, 10'b1100001000};
        tbl[13] = '{1'b1, 1'b1, 10'b1100000000};
        tbl[14] = '{1'b1, 1'b1, 10'b1100000000};
        tbl[15] = '{1'b0, 1'b1, 10'b0100000010};
        tbl[16] = '{1'b0, 1'b1, 10'b0101000000};
        tbl[17] = '{1'b1, 1'b1, 10'b1100000000};
        tbl[18] = '{1'b1, 1'b1, 10'b1110000000};

        en     = 1'b1;
        scl    = 1'b1;
        sda    = 1'b1;
        t_filt = FW'(DEF_T_FILT);
        t_free = CW'(DEF_T_BUS_FREE);
        t_idle = CW'(DEF_T_BUS_IDLE);

        // reset state, then free/idle timing from reset
        #12;
        chk("reset_outs", 32'(outs()), 32'h300);
        tick();
        rst_n = 1'b1;
        bad = 1'b0;
        for (int c = 1; c <= 51; c++) begin
            tick();
            if (busy) bad = 1'b1;
            if (c == 10) chk("free_c10", 32'(free), 0);
            if (c == 11) chk("free_c11", 32'(free), 1);
            if (c == 50) chk("idle_c50", 32'(idle), 0);
            if (c == 51) chk("idle_c51", 32'(idle), 1);
        end
        chk("busy_low_from_reset", 32'(bad), 0);

        // 3-cycle SDA glitch with t_filt=3 is suppressed
        bad = 1'b0;
        sda = 1'b0;
        for (int c = 0; c < 9; c++) begin
            if (c == 3) sda = 1'b1;
            tick();
            if (!sda_o || scl_pos || scl_neg || start_det ||
                rstart_det || stop_det) bad = 1'b1;
        end
        chk("glitch_suppressed", 32'(bad), 0);
        chk("glitch_idle_kept", 32'(idle), 1);

        // 4-cycle low passes and yields START
        sda = 1'b0;
        repeat (3) tick();
        chk("filt_lat_c3", 32'(sda_o), 1);
        tick();
        chk("filt_lat_c4", 32'(sda_o), 0);
        chk("start_not_yet", 32'(start_det), 0);
        tick();
        chk("start_c5", 32'(start_det), 1);
        chk("busy_after_start", 32'(busy), 1);
        chk("idle_cleared", 32'(idle), 0);
        tick();
        chk("start_one_cycle", 32'(start_det), 0);

        // table-driven transfer with t_filt=0
        rst_n  = 1'b0;
        t_filt = '0;
        t_free = CW'(2);
        t_idle = CW'(4);
        scl    = 1'b1;
        sda    = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 19; i++) begin
            scl = tbl[i].scl;
            sda = tbl[i].sda;
            tick();
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // simultaneous SCL/SDA changes inside a transfer
        scl = 1'b1; sda = 1'b0;
        tick(); tick();
        chk("sim_pre_start", 32'(start_det), 1);
        scl = 1'b0; sda = 1'b0;
        tick(); tick();
        scl = 1'b1; sda = 1'b1;
        tick(); tick();
        chk("sim_rise_pos", 32'(scl_pos), 1);
        chk("sim_rise_nostop", 32'(stop_det), 0);
        chk("sim_rise_busy", 32'(busy), 1);
        scl = 1'b0; sda = 1'b0;
        tick(); tick();
        chk("sim_fall_neg", 32'(scl_neg), 1);
        chk("sim_fall_nostart", 32'(start_det | rstart_det), 0);
        chk("sim_fall_busy", 32'(busy), 1);

        // reset mid-transfer with both lines low
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", 32'(outs()), 32'h300);
        tick();
        rst_n  = 1'b1;
        t_free = CW'(4);
        bad = 1'b0;
        repeat (3) begin
            tick();
            if (free || start_det || rstart_det) bad = 1'b1;
        end
        chk("midrst_low_quiet", 32'(bad), 0);
        scl = 1'b1; sda = 1'b1;
        repeat (5) tick();
        chk("midrst_free_c5", 32'(free), 0);
        tick();
        chk("midrst_free_c6", 32'(free), 1);
        sda = 1'b0;
        tick(); tick();
        chk("midrst_first_start", 32'(start_det), 1);
        chk("midrst_no_rstart", 32'(rstart_det), 0);

        // STOP back to free, then START while disabled
        sda = 1'b1;
        repeat (8) tick();
        chk("en_pre_free", 32'(free), 1);
        en  = 1'b0;
        sda = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            tick();
            if (start_det || rstart_det || busy || free || scl_pos ||
                scl_neg || stop_det) bad = 1'b1;
        end
        chk("dis_quiet", 32'(bad), 0);
        sda = 1'b1;
        tick(); tick();
        en = 1'b1;
        tick();
        chk("reen_no_stop", 32'(stop_det), 0);
        chk("reen_free_wait", 32'(free), 0);
        sda = 1'b0;
        tick(); tick();
        chk("reen_start", 32'(start_det), 1);
        chk("reen_no_rstart", 32'(rstart_det), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i3c_bus_monitor.md
# i3c_bus_monitor

Bus-condition monitor that sits directly downstream of the I3C PHY and consumes its synchronized SCL/SDA line values. It applies a per-line programmable glitch filter, derives SCL edge pulses and START / repeated-START / STOP pulses, and tracks bus busy / free / idle through timed states. The controller and target FSMs use its outputs to frame transfers and to arbitrate bus ownership.

## Interface
- FILT_W, 4: width of the glitch-filter threshold and counters.
- CNT_W, 20: width of the bus-free/idle threshold and timer.

- clk_i  in  1  system clock; the only clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- enable_i  in  1  monitor enable.
- scl_i  in  1  synchronized SCL from PHY.
- sda_i  in  1  synchronized SDA from PHY.
- t_filt_i  in  FILT_W  stable-cycle threshold for the filters.
- t_bus_free_i  in  CNT_W  cycles with both lines high before bus free.
- t_bus_idle_i  in  CNT_W  cycles with both lines high before bus idle.
- scl_o, sda_o  out  1  filtered line values.
- scl_posedge_o, scl_negedge_o  out  1  one-cycle filtered SCL edge pulses.
- start_det_o, rstart_det_o, stop_det_o  out  1  one-cycle condition pulses.
- bus_busy_o, bus_free_o, bus_idle_o  out  1  bus state levels.

## Operation
- Filter, one per line: the counter clears whenever raw equals filtered. While they differ, the counter increments each cycle. On the edge where the counter equals t_filt_i, filtered takes raw and the counter clears. A glitch shorter than t_filt_i+1 cycles is suppressed. The counter saturates and does not wrap.
- Edges: previous filtered values are held in scl_q/sda_q. All pulses are registered from the (q, filtered) comparison.
- START: sda 1→0 while scl_q=1 and scl=1. Pulses rstart_det_o if the state is BUSY, otherwise start_det_o. Either case enters BUSY.
- STOP: sda 0→1 while scl_q=1 and scl=1. Pulses stop_det_o, enters FREE_WAIT, clears the timer.
- Simultaneous SCL and SDA change in one cycle: only the SCL edge pulse fires; no START/STOP.
- FSM states: FREE_WAIT, FREE, IDLE, BUSY.
  - FREE_WAIT: if both lines are high, the timer increments (saturating); otherwise it clears. Timer ≥ t_bus_free_i → FREE.
  - FREE: the timer keeps counting. Timer ≥ t_bus_idle_i → IDLE. If t_bus_idle_i ≤ t_bus_free_i, IDLE follows FREE one cycle later.
  - FREE/IDLE: SCL falling without a START → FREE_WAIT, timer cleared.
  - BUSY: left only on STOP.
- Outputs: bus_busy_o = BUSY; bus_free_o = FREE or IDLE; bus_idle_o = IDLE.
- enable_i=0: the filters keep running. The FSM is forced to FREE_WAIT with the timer at 0, and all pulses are held low. Monitoring resumes on the first cycle enable_i=1.
- Threshold inputs are sampled every cycle. A change mid-count applies immediately.

## Timing
- Reset values: scl_o=1, sda_o=1, scl_q=1, sda_q=1, all pulses 0, all levels 0, state FREE_WAIT, all counters 0.
- Raw→filtered latency: t_filt_i+1 cycles. Raw→pulse latency: t_filt_i+2 cycles.
- Pulses are exactly one cycle wide. A level output changes in the same cycle as its transition pulse.
- Reset mid-transfer: the monitor returns to FREE_WAIT. bus_free_o is not asserted until both lines have been high for t_bus_free_i cycles. The first observed START reports start_det_o, not rstart_det_o.

## Structure
- i3c_pkg holds the shared items: enum bus_state_e {FREE_WAIT, FREE, IDLE, BUSY} and the default threshold localparams.
- Sub-module i3c_line_filter (FILT_W parameter; ports clk_i, rst_ni, raw, threshold, filtered) is instantiated once for SCL and once for SDA. Its reset value is 1.

## Test plan
- t_filt_i=3, 3-cycle low glitch on SDA while SCL high → no sda_o change, no pulses. A 4-cycle low gives sda_o=0 four cycles after the raw fall and start_det_o on the following cycle.
- t_bus_free_i=10, t_bus_idle_i=50, both lines high from reset → bus_free_o rises on the 11th cycle, bus_idle_o on the 51st, bus_busy_o stays 0.
- START, SCL toggling, second SDA fall with SCL high, then STOP → start_det_o once, rstart_det_o once, stop_det_o once, busy high between START and STOP.
- SCL and SDA changed in the same cycle (t_filt_i=0) → only the SCL edge pulse; the state is unchanged.
- rst_ni asserted mid-transfer with both lines low, then released → all outputs at reset values; bus_free_o stays 0 until lines are high for t_bus_free_i cycles.
- enable_i=0 during a START → no pulse and the state stays FREE_WAIT. After enable_i returns to 1, the next START gives start_det_o.
